// File: rtl/modular_addition_384_serial.sv
// Word-serial (x + y) mod M over the BLS12-381 base field, one LIMB_W-bit limb per cycle.
// Sum and sum-minus-M limbs are built in parallel, and the final carry/borrow picks one of them.
module modular_addition_384_serial #(
  parameter int LIMB_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] x_add,
  input  logic [383:0] y_add,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] z_add
);

  localparam int NLIMB = 384 / LIMB_W;
  localparam int CNT_W = $clog2(NLIMB);
  localparam logic [383:0] M =
    384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [383:0]       x_q, y_q, s_q, t_q;
  logic [383:0]       s_next, t_next;
  logic               c_q, b_q;
  logic [CNT_W-1:0]   cnt;
  logic [LIMB_W:0]    sum, diff;
  logic               last_limb, sel, accept;
  int                 idx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_limb = (cnt == CNT_W'(NLIMB - 1));
  // Carry out means x+y overflowed 2^384; no borrow means the sum is at least M.
  assign sel       = sum[LIMB_W] | ~diff[LIMB_W];

  // NOTE: every variable assigned here gets a full default first so no latch is inferred.
  always_comb begin
    idx    = int'(cnt) * LIMB_W;
    sum    = {1'b0, x_q[idx +: LIMB_W]} + {1'b0, y_q[idx +: LIMB_W]}
             + {{LIMB_W{1'b0}}, c_q};
    diff   = {1'b0, sum[LIMB_W-1:0]} - {1'b0, M[idx +: LIMB_W]}
             - {{LIMB_W{1'b0}}, b_q};
    s_next = s_q;
    t_next = t_q;
    s_next[idx +: LIMB_W] = sum[LIMB_W-1:0];
    t_next[idx +: LIMB_W] = diff[LIMB_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_limb) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      s_q   <= '0;
      t_q   <= '0;
      c_q   <= 1'b0;
      b_q   <= 1'b0;
      cnt   <= '0;
      z_add <= '0;
    end else begin
      if (accept) begin
        x_q <= x_add;
        y_q <= y_add;
        c_q <= 1'b0;
        b_q <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        s_q <= s_next;
        t_q <= t_next;
        c_q <= sum[LIMB_W];
        b_q <= diff[LIMB_W];
        cnt <= cnt + 1'b1;
        if (last_limb) z_add <= sel ? t_next : s_next;
      end
    end
  end

endmodule
